nmu_req_issuer: RTL and testbench

Front-end request stage of the NoC master unit. It accepts AXI read/write address-channel requests and drives the downstream address-map lookup (`lookup_en`, `next_req`). It collects the one or two mapped segments that come back (`dest_en`) and packs each one into a NoC request header. Headers go into a small FIFO and out on a valid/ready port to the packetizer.

---
 rtl/nmu_req_issuer_if.sv | 56 +++++
 rtl/nmu_req_issuer.sv | 176 +++++++++++++++++
 tb/tb_nmu_req_issuer.sv | 431 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/nmu_req_issuer_if.sv
// Request-stage bus bundle for nmu_req_issuer: AXI address channel,
// address-map lookup handshake, header output, and status flags.
interface nmu_req_issuer_if #(
    parameter int AXI_ADDR_WIDTH = 32,
    parameter int ID_WIDTH       = 4,
    parameter int NODE_WIDTH     = 4,
    parameter int HDR_WIDTH      = AXI_ADDR_WIDTH + 8 + 2*NODE_WIDTH + ID_WIDTH + 2
);
    // AXI address channel
    logic                      s_avalid;
    logic                      s_aready;
    logic [AXI_ADDR_WIDTH-1:0] s_aaddr;
    logic [7:0]                s_alen;
    logic [ID_WIDTH-1:0]       s_aid;
    logic                      s_awrite;

    // Address-map lookup
    logic                      lookup_en;
    logic [AXI_ADDR_WIDTH-1:0] map_addr;
    logic [7:0]                map_len;
    logic                      next_req;
    logic                      dest_en;
    logic [AXI_ADDR_WIDTH-1:0] dest_addr;
    logic [7:0]                dest_len;
    logic [NODE_WIDTH-1:0]     dest_id;
    logic                      lookup_done;

    // Header output and status
    logic                      m_hdr_valid;
    logic                      m_hdr_ready;
    logic [HDR_WIDTH-1:0]      m_hdr_data;
    logic                      busy;
    logic                      err;

    // Issuer side
    modport slave (
        input  s_avalid, s_aaddr, s_alen, s_aid, s_awrite,
        output s_aready,
        output lookup_en, map_addr, map_len, next_req,
        input  dest_en, dest_addr, dest_len, dest_id, lookup_done,
        output m_hdr_valid, m_hdr_data,
        input  m_hdr_ready,
        output busy, err
    );

    // Environment side (AXI master, map, packetizer)
    modport master (
        output s_avalid, s_aaddr, s_alen, s_aid, s_awrite,
        input  s_aready,
        input  lookup_en, map_addr, map_len, next_req,
        output dest_en, dest_addr, dest_len, dest_id, lookup_done,
        input  m_hdr_valid, m_hdr_data,
        output m_hdr_ready,
        input  busy, err
    );
endinterface

// File: rtl/nmu_req_issuer.sv
// NoC master unit request stage: accepts AXI address requests, drives the
// address-map lookup, packs the one or two returned segments into NoC
// request headers and queues them in a small FIFO for the packetizer.
module nmu_req_issuer #(
    parameter int                    AXI_ADDR_WIDTH = 32,
    parameter int                    ID_WIDTH       = 4,
    parameter int                    NODE_WIDTH     = 4,
    parameter logic [NODE_WIDTH-1:0] SRC_ID         = '0,
    parameter int                    FIFO_DEPTH     = 4,
    parameter int                    TIMEOUT        = 64,
    parameter int                    HDR_WIDTH      = AXI_ADDR_WIDTH + 8 + 2*NODE_WIDTH + ID_WIDTH + 2
) (
    input  logic              axi_clk,
    input  logic              axi_rst,
    nmu_req_issuer_if.slave   bus
);

    localparam int PW  = $clog2(FIFO_DEPTH);
    localparam int CW  = PW + 1;
    localparam int WDW = $clog2(TIMEOUT) + 1;
    localparam logic [WDW-1:0] WDOG_LAST = WDW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE,
        WAIT_SEG0,
        REQ_NEXT,
        WAIT_SEG1
    } state_t;

    state_t                    r_state;
    state_t                    w_next;

    logic                      r_lookup_en;
    logic [AXI_ADDR_WIDTH-1:0] r_map_addr;
    logic [7:0]                r_map_len;
    logic [ID_WIDTH-1:0]       r_aid;
    logic                      r_awrite;
    logic                      r_err;
    logic [WDW-1:0]            r_wdog;

    logic [HDR_WIDTH-1:0]      r_mem [FIFO_DEPTH];
    logic [PW-1:0]             r_wptr;
    logic [PW-1:0]             r_rptr;
    logic [CW-1:0]             r_count;

    logic [CW-1:0]             w_free;
    logic                      w_accept;
    logic                      w_timeout;
    logic                      w_push;
    logic                      w_pop;
    logic                      w_last;
    logic                      w_set_err;
    logic                      w_enter_wait;
    logic                      w_in_wait;
    logic [HDR_WIDTH-1:0]      w_hdr;

    // Two free slots are required so a split lookup can never meet a full FIFO
    assign w_free    = CW'(FIFO_DEPTH) - r_count;
    assign bus.s_aready = !axi_rst && (r_state == IDLE) && (w_free >= CW'(2));
    assign w_accept  = bus.s_avalid && bus.s_aready;
    assign w_timeout = (r_wdog == WDOG_LAST);
    assign w_pop     = (r_count != '0) && bus.m_hdr_ready;
    assign w_in_wait = (r_state == WAIT_SEG0) || (r_state == WAIT_SEG1);
    assign w_enter_wait = (w_next != r_state) && ((w_next == WAIT_SEG0) || (w_next == WAIT_SEG1));

    assign w_hdr = {w_last, r_awrite, r_aid, SRC_ID, bus.dest_id, bus.dest_len, bus.dest_addr};

    assign bus.lookup_en   = r_lookup_en;
    assign bus.next_req    = (r_state == REQ_NEXT);
    assign bus.map_addr    = r_map_addr;
    assign bus.map_len     = r_map_len;
    assign bus.m_hdr_valid = (r_count != '0);
    assign bus.m_hdr_data  = r_mem[r_rptr];
    assign bus.busy        = (r_state != IDLE) || (r_count != '0);
    assign bus.err         = r_err;

    // Next-state, header push and error decisions
    always_comb begin
        w_next    = r_state;
        w_push    = 1'b0;
        w_last    = 1'b0;
        w_set_err = 1'b0;
        case (r_state)
            IDLE: begin
                w_set_err = bus.dest_en;
                if (w_accept) w_next = WAIT_SEG0;
            end
            WAIT_SEG0: begin
                if (bus.dest_en) begin
                    w_push = 1'b1;
                    w_last = bus.lookup_done;
                    w_next = bus.lookup_done ? IDLE : REQ_NEXT;
                end else if (w_timeout) begin
                    w_set_err = 1'b1;
                    w_next    = IDLE;
                end
            end
            REQ_NEXT: begin
                w_set_err = bus.dest_en;
                w_next    = WAIT_SEG1;
            end
            WAIT_SEG1: begin
                if (bus.dest_en) begin
                    w_push    = 1'b1;
                    w_last    = 1'b1;
                    w_set_err = !bus.lookup_done;
                    w_next    = IDLE;
                end else if (w_timeout) begin
                    w_set_err = 1'b1;
                    w_next    = IDLE;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge axi_clk or posedge axi_rst) begin
        if (axi_rst) r_state <= IDLE;
        else         r_state <= w_next;
    end

    // Request capture and the lookup start pulse in the first WAIT_SEG0 cycle
    always_ff @(posedge axi_clk or posedge axi_rst) begin
        if (axi_rst) begin
            r_lookup_en <= 1'b0;
            r_map_addr  <= '0;
            r_map_len   <= '0;
            r_aid       <= '0;
            r_awrite    <= 1'b0;
        end else begin
            r_lookup_en <= w_accept;
            if (w_accept) begin
                r_map_addr <= bus.s_aaddr;
                r_map_len  <= bus.s_alen;
                r_aid      <= bus.s_aid;
                r_awrite   <= bus.s_awrite;
            end
        end
    end

    // Segment watchdog: restarts on entry to either wait state
    always_ff @(posedge axi_clk or posedge axi_rst) begin
        if (axi_rst)           r_wdog <= '0;
        else if (w_enter_wait) r_wdog <= '0;
        else if (w_in_wait)    r_wdog <= r_wdog + 1'b1;
    end

    // Sticky error flag
    always_ff @(posedge axi_clk or posedge axi_rst) begin
        if (axi_rst)        r_err <= 1'b0;
        else if (w_set_err) r_err <= 1'b1;
    end

    // Header FIFO; storage is cleared so the idle head reads as zero
    always_ff @(posedge axi_clk or posedge axi_rst) begin
        if (axi_rst) begin
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= '0;
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wptr] <= w_hdr;
                r_wptr        <= r_wptr + 1'b1;
            end
            if (w_pop) r_rptr <= r_rptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: tb/tb_nmu_req_issuer.sv
// Bench for nmu_req_issuer: randomized requests and map answers, expected
// headers built from field values and compared with a monitor's pop log.
module tb_nmu_req_issuer;

    localparam int AW    = 32;
    localparam int IW    = 4;
    localparam int NW    = 4;
    localparam int HW    = AW + 8 + 2*NW + IW + 2;
    localparam int DEPTH = 4;
    localparam int TO    = 64;
    localparam logic [NW-1:0] SRC = 4'h0;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    int   n_lookup = 0;
    int   n_next = 0;
    logic [HW-1:0] got_q[$];
    logic [HW-1:0] exp_q[$];

    always #5 clk = ~clk;

    nmu_req_issuer_if #(.AXI_ADDR_WIDTH(AW), .ID_WIDTH(IW), .NODE_WIDTH(NW)) bus ();

    nmu_req_issuer #(
        .AXI_ADDR_WIDTH(AW), .ID_WIDTH(IW), .NODE_WIDTH(NW), .SRC_ID(SRC),
        .FIFO_DEPTH(DEPTH), .TIMEOUT(TO)
    ) dut (
        .axi_clk(clk),
        .axi_rst(rst),
        .bus(bus)
    );

    // Monitor: pulses and popped headers, sampled mid-cycle
    always @(negedge clk) begin
        if (bus.lookup_en === 1'b1) n_lookup <= n_lookup + 1;
        if (bus.next_req === 1'b1)  n_next   <= n_next + 1;
        if (bus.m_hdr_valid === 1'b1 && bus.m_hdr_ready === 1'b1) got_q.push_back(bus.m_hdr_data);
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation still running, required finish");
        $fatal(1);
    end

    // Header built from its field list, LSB first
    function automatic logic [HW-1:0] mk_hdr(input logic [AW-1:0] a, input logic [7:0] l,
                                             input logic [NW-1:0] d, input logic [IW-1:0] id,
                                             input logic w, input logic last);
        longint unsigned v;
        v = 64'(a);
        v = v + (64'(l)    << AW);
        v = v + (64'(d)    << (AW + 8));
        v = v + (64'(SRC)  << (AW + 8 + NW));
        v = v + (64'(id)   << (AW + 8 + 2*NW));
        v = v + (64'(w)    << (AW + 8 + 2*NW + IW));
        v = v + (64'(last) << (AW + 8 + 2*NW + IW + 1));
        return v[HW-1:0];
    endfunction

    task automatic wait_cyc(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic apply_reset();
        bus.s_avalid = 1'b0;
        bus.dest_en  = 1'b0;
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        got_q.delete();
    endtask

    // Issue one request; returns just after the accepting edge
    task automatic do_req(input logic [AW-1:0] a, input logic [7:0] l, input logic [IW-1:0] id, input logic w);
        int k;
        k = 0;
        @(negedge clk);
        while (bus.s_aready !== 1'b1 && k < 500) begin @(negedge clk); k++; end
        checks++;
        if (bus.s_aready !== 1'b1) begin
            errors++; $display("FAIL accept_wait: s_aready=%0b required 1", bus.s_aready);
        end
        bus.s_avalid = 1'b1; bus.s_aaddr = a; bus.s_alen = l; bus.s_aid = id; bus.s_awrite = w;
        @(posedge clk); #1;
        bus.s_avalid = 1'b0;
    endtask

    // One-cycle map answer
    task automatic seg(input logic [AW-1:0] a, input logic [7:0] l, input logic [NW-1:0] d, input logic done);
        bus.dest_en = 1'b1; bus.dest_addr = a; bus.dest_len = l; bus.dest_id = d; bus.lookup_done = done;
        @(posedge clk); #1;
        bus.dest_en = 1'b0; bus.lookup_done = 1'b0;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks++;
        if ({bus.s_aready, bus.lookup_en, bus.next_req, bus.m_hdr_valid, bus.busy, bus.err} !== 6'b0) begin
            errors++; $display("FAIL reset_flags: aready/lookup/next/valid/busy/err=%b required 000000",
                {bus.s_aready, bus.lookup_en, bus.next_req, bus.m_hdr_valid, bus.busy, bus.err});
        end
        checks++;
        if (bus.map_addr !== '0 || bus.map_len !== '0 || bus.m_hdr_data !== '0) begin
            errors++; $display("FAIL reset_data: map_addr=%0h map_len=%0h hdr=%0h required 0",
                bus.map_addr, bus.map_len, bus.m_hdr_data);
        end
        @(posedge clk); #1; rst = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.s_aready !== 1'b1) begin
            errors++; $display("FAIL reset_release_aready: got %0b required 1", bus.s_aready);
        end
    endtask

    task automatic test_unsplit();
        logic [AW-1:0] a, da; logic [7:0] l, dl; logic [IW-1:0] id; logic [NW-1:0] did; logic w;
        int d, n0, x0; logic [HW-1:0] h;
        bus.m_hdr_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (i == 0) begin
                a = 32'h100; l = 8'd3; id = 4'd2; w = 1'b0; da = 32'h200; dl = 8'd3; did = 4'd3; d = 25;
            end else begin
                a = $urandom; l = 8'($urandom); id = IW'($urandom); w = 1'($urandom);
                da = $urandom; dl = 8'($urandom); did = NW'($urandom); d = int'($urandom_range(0, TO - 1));
            end
            h = mk_hdr(da, dl, did, id, w, 1'b1);
            got_q.delete(); n0 = n_lookup; x0 = n_next;
            do_req(a, l, id, w);
            @(negedge clk);
            checks++;
            if (bus.lookup_en !== 1'b1) begin
                errors++; $display("FAIL unsplit_lookup_en[%0d]: got %0b required 1", i, bus.lookup_en);
            end
            checks++;
            if (bus.map_addr !== a || bus.map_len !== l) begin
                errors++; $display("FAIL unsplit_map[%0d]: got %0h/%0h required %0h/%0h", i, bus.map_addr, bus.map_len, a, l);
            end
            if (d > 0) wait_cyc(d);
            seg(da, dl, did, 1'b1);
            @(negedge clk);
            checks++;
            if (bus.m_hdr_valid !== 1'b1 || bus.m_hdr_data !== h) begin
                errors++; $display("FAIL unsplit_hdr_latency[%0d]: valid=%0b data=%0h required 1/%0h", i, bus.m_hdr_valid, bus.m_hdr_data, h);
            end
            wait_cyc(3);
            checks++;
            if (got_q.size() != 1 || got_q[0] !== h) begin
                errors++; $display("FAIL unsplit_hdr[%0d]: got %0d hdrs first=%0h required 1 x %0h", i, got_q.size(),
                    (got_q.size() > 0) ? got_q[0] : '0, h);
            end
            checks++;
            if (n_lookup - n0 != 1 || n_next - x0 != 0 || bus.err !== 1'b0) begin
                errors++; $display("FAIL unsplit_pulses[%0d]: lookup=%0d next=%0d err=%0b required 1/0/0", i, n_lookup - n0, n_next - x0, bus.err);
            end
        end
    endtask

    task automatic test_split();
        logic [AW-1:0] a, a1, a2; logic [7:0] l; logic [IW-1:0] id; logic [NW-1:0] d1, d2; logic w;
        int d, n0, x0;
        bus.m_hdr_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            a = $urandom; l = 8'($urandom); id = IW'($urandom); w = 1'($urandom);
            a1 = $urandom; a2 = $urandom; d1 = NW'($urandom); d2 = NW'($urandom);
            d = int'($urandom_range(0, 10));
            exp_q.delete(); got_q.delete(); n0 = n_lookup; x0 = n_next;
            exp_q.push_back(mk_hdr(a1, 8'd1, d1, id, w, 1'b0));
            exp_q.push_back(mk_hdr(a2, 8'd2, d2, id, w, 1'b1));
            do_req(a, l, id, w);
            if (d > 0) wait_cyc(d);
            seg(a1, 8'd1, d1, 1'b0);
            @(negedge clk);
            checks++;
            if (bus.next_req !== 1'b1) begin
                errors++; $display("FAIL split_next_req[%0d]: got %0b required 1", i, bus.next_req);
            end
            wait_cyc(1);
            @(negedge clk);
            checks++;
            if (bus.next_req !== 1'b0) begin
                errors++; $display("FAIL split_next_req_width[%0d]: got %0b required 0", i, bus.next_req);
            end
            seg(a2, 8'd2, d2, 1'b1);
            wait_cyc(3);
            checks++;
            if (got_q.size() != 2) begin
                errors++; $display("FAIL split_hdr_count[%0d]: got %0d required 2", i, got_q.size());
            end else begin
                for (int k = 0; k < 2; k++) begin
                    checks++;
                    if (got_q[k] !== exp_q[k]) begin
                        errors++; $display("FAIL split_hdr[%0d][%0d]: got %0h required %0h", i, k, got_q[k], exp_q[k]);
                    end
                end
            end
            checks++;
            if (n_lookup - n0 != 1 || n_next - x0 != 1 || bus.err !== 1'b0) begin
                errors++; $display("FAIL split_pulses[%0d]: lookup=%0d next=%0d err=%0b required 1/1/0", i, n_lookup - n0, n_next - x0, bus.err);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [AW-1:0] a; logic [7:0] l; logic [IW-1:0] id; logic [NW-1:0] did; logic w;
        bus.m_hdr_ready = 1'b0;
        got_q.delete(); exp_q.delete();
        for (int i = 0; i < 2; i++) begin
            id = IW'($urandom); w = 1'($urandom); a = $urandom; l = 8'($urandom); did = NW'($urandom);
            do_req($urandom, 8'($urandom), id, w);
            wait_cyc(int'($urandom_range(0, 5)));
            seg(a, l, did, 1'b1);
            exp_q.push_back(mk_hdr(a, l, did, id, w, 1'b1));
        end
        wait_cyc(1);
        @(negedge clk);
        checks++;
        if (bus.s_aready !== 1'b1) begin
            errors++; $display("FAIL bp_ready_count2: got %0b required 1", bus.s_aready);
        end
        id = IW'($urandom); w = 1'($urandom);
        do_req($urandom, 8'($urandom), id, w);
        a = $urandom; did = NW'($urandom);
        seg(a, 8'd1, did, 1'b0);
        exp_q.push_back(mk_hdr(a, 8'd1, did, id, w, 1'b0));
        wait_cyc(1);
        a = $urandom; did = NW'($urandom);
        seg(a, 8'd2, did, 1'b1);
        exp_q.push_back(mk_hdr(a, 8'd2, did, id, w, 1'b1));
        wait_cyc(1);
        @(negedge clk);
        checks++;
        if (bus.s_aready !== 1'b0 || bus.m_hdr_valid !== 1'b1) begin
            errors++; $display("FAIL bp_full: aready=%0b valid=%0b required 0/1", bus.s_aready, bus.m_hdr_valid);
        end
        wait_cyc(5);
        @(negedge clk);
        checks++;
        if (bus.s_aready !== 1'b0) begin
            errors++; $display("FAIL bp_hold: aready=%0b required 0", bus.s_aready);
        end
        for (int p = 1; p <= 2; p++) begin
            @(posedge clk); #1; bus.m_hdr_ready = 1'b1;
            @(posedge clk); #1; bus.m_hdr_ready = 1'b0;
            @(negedge clk);
            checks++;
            if (bus.s_aready !== ((DEPTH - 4 + p) >= 2)) begin
                errors++; $display("FAIL bp_after_pop%0d: aready=%0b required %0b", p, bus.s_aready, ((DEPTH - 4 + p) >= 2));
            end
        end
        @(posedge clk); #1; bus.m_hdr_ready = 1'b1;
        wait_cyc(4);
        checks++;
        if (got_q.size() != 4) begin
            errors++; $display("FAIL bp_hdr_count: got %0d required 4", got_q.size());
        end else begin
            for (int k = 0; k < 4; k++) begin
                checks++;
                if (got_q[k] !== exp_q[k]) begin
                    errors++; $display("FAIL bp_hdr[%0d]: got %0h required %0h", k, got_q[k], exp_q[k]);
                end
            end
        end
    endtask

    task automatic test_push_pop();
        logic [HW-1:0] ha, hb; logic [AW-1:0] a; logic [IW-1:0] id; logic [NW-1:0] did; logic w; logic [7:0] l;
        bus.m_hdr_ready = 1'b0;
        got_q.delete();
        a = $urandom; l = 8'($urandom); id = IW'($urandom); w = 1'($urandom); did = NW'($urandom);
        ha = mk_hdr(a, l, did, id, w, 1'b1);
        do_req($urandom, l, id, w);
        seg(a, l, did, 1'b1);
        wait_cyc(2);
        @(negedge clk);
        checks++;
        if (bus.m_hdr_valid !== 1'b1 || bus.m_hdr_data !== ha) begin
            errors++; $display("FAIL pp_setup: valid=%0b data=%0h required 1/%0h", bus.m_hdr_valid, bus.m_hdr_data, ha);
        end
        a = $urandom; l = 8'($urandom); id = IW'($urandom); w = 1'($urandom); did = NW'($urandom);
        hb = mk_hdr(a, l, did, id, w, 1'b1);
        do_req($urandom, l, id, w);
        wait_cyc(3);
        bus.m_hdr_ready = 1'b1;
        seg(a, l, did, 1'b1);
        bus.m_hdr_ready = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.m_hdr_valid !== 1'b1 || bus.m_hdr_data !== hb) begin
            errors++; $display("FAIL pp_count_kept: valid=%0b data=%0h required 1/%0h", bus.m_hdr_valid, bus.m_hdr_data, hb);
        end
        @(posedge clk); #1; bus.m_hdr_ready = 1'b1;
        @(posedge clk); #1; bus.m_hdr_ready = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.m_hdr_valid !== 1'b0) begin
            errors++; $display("FAIL pp_drained: valid=%0b required 0", bus.m_hdr_valid);
        end
        checks++;
        if (got_q.size() != 2 || got_q[0] !== ha || got_q[1] !== hb) begin
            errors++; $display("FAIL pp_order: got %0d hdrs required 2 in order %0h,%0h", got_q.size(), ha, hb);
        end
    endtask

    task automatic test_errors();
        logic [AW-1:0] a1, a2; logic [IW-1:0] id; logic [NW-1:0] d1, d2; logic w;
        bus.m_hdr_ready = 1'b1;
        apply_reset();
        checks++;
        if (bus.err !== 1'b0) begin
            errors++; $display("FAIL err_cleared: got %0b required 0", bus.err);
        end
        wait_cyc(1);
        seg($urandom, 8'($urandom), NW'($urandom), 1'b1);
        @(negedge clk);
        checks++;
        if (bus.err !== 1'b1 || bus.m_hdr_valid !== 1'b0 || bus.busy !== 1'b0) begin
            errors++; $display("FAIL stray_dest_en: err=%0b valid=%0b busy=%0b required 1/0/0", bus.err, bus.m_hdr_valid, bus.busy);
        end
        apply_reset();
        id = IW'($urandom); w = 1'($urandom); a1 = $urandom; a2 = $urandom; d1 = NW'($urandom); d2 = NW'($urandom);
        do_req($urandom, 8'($urandom), id, w);
        seg(a1, 8'd1, d1, 1'b0);
        wait_cyc(1);
        seg(a2, 8'd2, d2, 1'b0);
        wait_cyc(3);
        checks++;
        if (got_q.size() != 2 || got_q[0] !== mk_hdr(a1, 8'd1, d1, id, w, 1'b0) || got_q[1] !== mk_hdr(a2, 8'd2, d2, id, w, 1'b1)) begin
            errors++; $display("FAIL seg1_not_done_hdrs: got %0d hdrs required 2 with last=0,1", got_q.size());
        end
        checks++;
        if (bus.err !== 1'b1) begin
            errors++; $display("FAIL seg1_not_done_err: got %0b required 1", bus.err);
        end
    endtask

    task automatic test_timeout();
        logic [AW-1:0] a; logic [7:0] l; logic [IW-1:0] id; logic [NW-1:0] did; logic w;
        bus.m_hdr_ready = 1'b1;
        apply_reset();
        a = $urandom; l = 8'($urandom); id = IW'($urandom); w = 1'($urandom); did = NW'($urandom);
        do_req($urandom, 8'($urandom), id, w);
        wait_cyc(TO - 1);
        seg(a, l, did, 1'b1);
        wait_cyc(3);
        checks++;
        if (got_q.size() != 1 || got_q[0] !== mk_hdr(a, l, did, id, w, 1'b1) || bus.err !== 1'b0) begin
            errors++; $display("FAIL timeout_last_cycle_answer: hdrs=%0d err=%0b required 1/0", got_q.size(), bus.err);
        end
        got_q.delete();
        do_req($urandom, 8'($urandom), IW'($urandom), 1'($urandom));
        wait_cyc(TO - 1);
        @(negedge clk);
        checks++;
        if (bus.err !== 1'b0 || bus.busy !== 1'b1) begin
            errors++; $display("FAIL timeout_early: err=%0b busy=%0b required 0/1", bus.err, bus.busy);
        end
        wait_cyc(1);
        @(negedge clk);
        checks++;
        if (bus.err !== 1'b1 || bus.busy !== 1'b0 || bus.s_aready !== 1'b1 || bus.m_hdr_valid !== 1'b0) begin
            errors++; $display("FAIL timeout_fire: err=%0b busy=%0b aready=%0b valid=%0b required 1/0/1/0",
                bus.err, bus.busy, bus.s_aready, bus.m_hdr_valid);
        end
        wait_cyc(3);
        checks++;
        if (got_q.size() != 0) begin
            errors++; $display("FAIL timeout_no_hdr: got %0d hdrs required 0", got_q.size());
        end
    endtask

    task automatic test_reset_seg1();
        int n0, x0;
        bus.m_hdr_ready = 1'b0;
        apply_reset();
        do_req($urandom, 8'($urandom), IW'($urandom), 1'($urandom));
        seg($urandom, 8'd1, NW'($urandom), 1'b0);
        wait_cyc(1);
        @(negedge clk);
        checks++;
        if (bus.m_hdr_valid !== 1'b1 || bus.busy !== 1'b1) begin
            errors++; $display("FAIL rst_seg1_setup: valid=%0b busy=%0b required 1/1", bus.m_hdr_valid, bus.busy);
        end
        rst = 1'b1;
        #1;
        checks++;
        if ({bus.s_aready, bus.lookup_en, bus.next_req, bus.m_hdr_valid, bus.busy, bus.err} !== 6'b0) begin
            errors++; $display("FAIL rst_seg1_flags: aready/lookup/next/valid/busy/err=%b required 000000",
                {bus.s_aready, bus.lookup_en, bus.next_req, bus.m_hdr_valid, bus.busy, bus.err});
        end
        checks++;
        if (bus.map_addr !== '0 || bus.map_len !== '0 || bus.m_hdr_data !== '0) begin
            errors++; $display("FAIL rst_seg1_data: map_addr=%0h map_len=%0h hdr=%0h required 0",
                bus.map_addr, bus.map_len, bus.m_hdr_data);
        end
        n0 = n_lookup; x0 = n_next;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        bus.m_hdr_ready = 1'b1;
        got_q.delete();
        wait_cyc(10);
        @(negedge clk);
        checks++;
        if (n_lookup != n0 || n_next != x0 || got_q.size() != 0 || bus.m_hdr_valid !== 1'b0) begin
            errors++; $display("FAIL rst_seg1_quiet: lookups=%0d nexts=%0d hdrs=%0d valid=%0b required 0/0/0/0",
                n_lookup - n0, n_next - x0, got_q.size(), bus.m_hdr_valid);
        end
        checks++;
        if (bus.s_aready !== 1'b1) begin
            errors++; $display("FAIL rst_seg1_aready: got %0b required 1", bus.s_aready);
        end
    endtask

    initial begin
        bus.s_avalid = 1'b0; bus.s_aaddr = '0; bus.s_alen = '0; bus.s_aid = '0; bus.s_awrite = 1'b0;
        bus.dest_en = 1'b0; bus.dest_addr = '0; bus.dest_len = '0; bus.dest_id = '0; bus.lookup_done = 1'b0;
        bus.m_hdr_ready = 1'b0;
        test_reset();
        test_unsplit();
        test_split();
        test_backpressure();
        test_push_pop();
        test_errors();
        test_timeout();
        test_reset_seg1();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
